// File: rtl/ysyx_22040750_clint_pkg.sv
// Shared constants for the CLINT: register offsets, default window base,
// read/write FSM encodings and the byte-strobe merge helper.
package ysyx_22040750_clint_pkg;

    localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;

    localparam logic [31:0] CLINT_BASE_ADDR    = 32'h0200_0000;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;

    function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_v;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
            else         res[b*8 +: 8] = old_v[b*8 +: 8];
        end
        return res;
    endfunction

    function automatic logic lane_is(input logic [12:0] lane, input logic [15:0] ofs);
        return lane == ofs[15:3];
    endfunction

endpackage

// File: rtl/ysyx_22040750_clint_timer.sv
// mtime/mtimecmp block: prescaler, byte-strobed register writes and the
// registered mtime >= mtimecmp compare that drives the timer interrupt.
module ysyx_22040750_clint_timer
    import ysyx_22040750_clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_time,
    input  logic        wr_cmp,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        mtip
);

    localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc_r;
    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic        mtip_r;
    logic        tick_s;

    assign tick_s = (presc_r == DIV_LAST);

    // prescaler counting 0..TICK_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      presc_r <= 16'h0000;
        else if (tick_s) presc_r <= 16'h0000;
        else             presc_r <= presc_r + 16'h0001;
    end

    // mtime: a software write overrides a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mtime_r <= 64'h0;
        else if (wr_time) mtime_r <= strb_merge(mtime_r, wdata, wstrb);
        else if (tick_s)  mtime_r <= mtime_r + 64'h1;
        else              mtime_r <= mtime_r;
    end

    // mtimecmp write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
        else if (wr_cmp) mtimecmp_r <= strb_merge(mtimecmp_r, wdata, wstrb);
        else             mtimecmp_r <= mtimecmp_r;
    end

    // registered unsigned compare of the current register contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mtip_r <= 1'b0;
        else        mtip_r <= (mtime_r >= mtimecmp_r);
    end

    assign mtime    = mtime_r;
    assign mtimecmp = mtimecmp_r;
    assign mtip     = mtip_r;

endmodule

// File: rtl/ysyx_22040750_clint.sv
// CLINT AXI4-Lite slave: independent read/write FSMs, msip, and the timer block.
// msip is implemented only when YSYX_22040750_CLINT_MSIP_EN is defined.
module ysyx_22040750_clint
    import ysyx_22040750_clint_pkg::*;
#(
    parameter int          TICK_DIV  = 1,
    parameter logic [31:0] BASE_ADDR = CLINT_BASE_ADDR
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [31:0] I_araddr,
    input  logic        I_arvalid,
    output logic        O_arready,
    output logic [63:0] O_rdata,
    output logic        O_rvalid,
    input  logic        I_rready,
    input  logic [31:0] I_awaddr,
    input  logic        I_awvalid,
    output logic        O_awready,
    input  logic [63:0] I_wdata,
    input  logic [7:0]  I_wstrb,
    input  logic        I_wvalid,
    output logic        O_wready,
    output logic        O_bvalid,
    input  logic        I_bready,
    output logic        O_mtip,
    output logic        O_msip
);

    logic [0:0]  rstate_r;
    logic [0:0]  wstate_r;
    logic [63:0] rdata_r;
    logic [63:0] rd_mux_s;
    logic [63:0] mtime_s;
    logic [63:0] mtimecmp_s;
    logic        msip_s;
    logic        ar_win_s;
    logic        aw_win_s;
    logic        aw_fire_s;
    logic [12:0] ar_lane_s;
    logic [12:0] aw_lane_s;

    assign ar_win_s  = (I_araddr[31:16] == BASE_ADDR[31:16]);
    assign aw_win_s  = (I_awaddr[31:16] == BASE_ADDR[31:16]);
    assign ar_lane_s = I_araddr[15:3];
    assign aw_lane_s = I_awaddr[15:3];
    assign aw_fire_s = (wstate_r == W_IDLE) & I_awvalid & I_wvalid;

    // read data mux over the current (pre-write) register values
    always_comb begin
        rd_mux_s = 64'h0;
        if (!ar_win_s)                                 rd_mux_s = 64'h0;
        else if (lane_is(ar_lane_s, CLINT_MSIP_OFS))     rd_mux_s = {63'h0, msip_s};
        else if (lane_is(ar_lane_s, CLINT_MTIMECMP_OFS)) rd_mux_s = mtimecmp_s;
        else if (lane_is(ar_lane_s, CLINT_MTIME_OFS))    rd_mux_s = mtime_s;
        else                                           rd_mux_s = 64'h0;
    end

    // read FSM; data is captured on the ar handshake and held until rready
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            rstate_r <= R_IDLE;
            rdata_r  <= 64'h0;
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    if (I_arvalid) begin
                        rstate_r <= R_DATA;
                        rdata_r  <= rd_mux_s;
                    end
                end
                R_DATA: begin
                    if (I_rready) rstate_r <= R_IDLE;
                end
                default: rstate_r <= R_IDLE;
            endcase
        end
    end

    // write FSM; aw and w are only accepted together
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            wstate_r <= W_IDLE;
        end else begin
            case (wstate_r)
                W_IDLE:  if (aw_fire_s) wstate_r <= W_RESP;
                W_RESP:  if (I_bready)  wstate_r <= W_IDLE;
                default: wstate_r <= W_IDLE;
            endcase
        end
    end

`ifdef YSYX_22040750_CLINT_MSIP_EN
    logic msip_r;
    logic wr_msip_s;

    assign wr_msip_s = aw_fire_s & aw_win_s & lane_is(aw_lane_s, CLINT_MSIP_OFS);

    // msip bit 0, byte lane 0 only
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst)                       msip_r <= 1'b0;
        else if (wr_msip_s && I_wstrb[0]) msip_r <= I_wdata[0];
        else                              msip_r <= msip_r;
    end

    assign msip_s = msip_r;
`else
    assign msip_s = 1'b0;
`endif

    ysyx_22040750_clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk      (I_clk),
        .rst_n    (I_rst),
        .wr_time  (aw_fire_s & aw_win_s & lane_is(aw_lane_s, CLINT_MTIME_OFS)),
        .wr_cmp   (aw_fire_s & aw_win_s & lane_is(aw_lane_s, CLINT_MTIMECMP_OFS)),
        .wdata    (I_wdata),
        .wstrb    (I_wstrb),
        .mtime    (mtime_s),
        .mtimecmp (mtimecmp_s),
        .mtip     (O_mtip)
    );

    assign O_arready = (rstate_r == R_IDLE);
    assign O_rvalid  = (rstate_r == R_DATA);
    assign O_rdata   = rdata_r;
    assign O_awready = aw_fire_s;
    assign O_wready  = aw_fire_s;
    assign O_bvalid  = (wstate_r == W_RESP);
    assign O_msip    = msip_s;

endmodule

// File: tb/tb_ysyx_22040750_clint.sv
// Bench for ysyx_22040750_clint: two instances (TICK_DIV 1 and 4) share one
// stimulus stream and are compared against an arithmetic model of mtime.
module tb_ysyx_22040750_clint;

    localparam logic [31:0] BASE   = 32'h0200_0000;
    localparam logic [31:0] A_MSIP = 32'h0200_0000;
    localparam logic [31:0] A_CMP  = 32'h0200_4000;
    localparam logic [31:0] A_TIME = 32'h0200_BFF8;
`ifdef YSYX_22040750_CLINT_MSIP_EN
    localparam bit MSIP_EN = 1'b1;
`else
    localparam bit MSIP_EN = 1'b0;
`endif

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b0;
    logic [31:0] I_araddr = 32'h0;
    logic        I_arvalid = 1'b0;
    logic        I_rready = 1'b0;
    logic [31:0] I_awaddr = 32'h0;
    logic        I_awvalid = 1'b0;
    logic [63:0] I_wdata = 64'h0;
    logic [7:0]  I_wstrb = 8'h00;
    logic        I_wvalid = 1'b0;
    logic        I_bready = 1'b0;

    logic [63:0] rdata   [2];
    logic        arready [2];
    logic        rvalid  [2];
    logic        awready [2];
    logic        wready  [2];
    logic        bvalid  [2];
    logic        mtip    [2];
    logic        msip    [2];

    always #5 I_clk = ~I_clk;

    ysyx_22040750_clint #(.TICK_DIV(1)) dut1 (
        .I_clk(I_clk), .I_rst(I_rst),
        .I_araddr(I_araddr), .I_arvalid(I_arvalid), .O_arready(arready[0]),
        .O_rdata(rdata[0]), .O_rvalid(rvalid[0]), .I_rready(I_rready),
        .I_awaddr(I_awaddr), .I_awvalid(I_awvalid), .O_awready(awready[0]),
        .I_wdata(I_wdata), .I_wstrb(I_wstrb), .I_wvalid(I_wvalid), .O_wready(wready[0]),
        .O_bvalid(bvalid[0]), .I_bready(I_bready),
        .O_mtip(mtip[0]), .O_msip(msip[0])
    );

    ysyx_22040750_clint #(.TICK_DIV(4)) dut4 (
        .I_clk(I_clk), .I_rst(I_rst),
        .I_araddr(I_araddr), .I_arvalid(I_arvalid), .O_arready(arready[1]),
        .O_rdata(rdata[1]), .O_rvalid(rvalid[1]), .I_rready(I_rready),
        .I_awaddr(I_awaddr), .I_awvalid(I_awvalid), .O_awready(awready[1]),
        .I_wdata(I_wdata), .I_wstrb(I_wstrb), .I_wvalid(I_wvalid), .O_wready(wready[1]),
        .O_bvalid(bvalid[1]), .I_bready(I_bready),
        .O_mtip(mtip[1]), .O_msip(msip[1])
    );

    int errors = 0;
    int checks = 0;
    int edge_n;

    // edges completed since reset release
    always @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    // reference model: mtime = value written at edge base_e plus ticks since then
    longint unsigned base_v [2];
    int              base_e [2];
    longint unsigned cmp_v  [2];
    logic            msip_v;
    logic            pend_valid;
    logic [31:0]     pend_addr;
    logic [63:0]     pend_data;
    logic [7:0]      pend_strb;
    logic [63:0]     rd_obs [2];

    function automatic int div_of(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic longint unsigned tm(int i, int c);
        return base_v[i] + 64'(c / div_of(i)) - 64'((base_e[i] + 1) / div_of(i));
    endfunction

    function automatic logic [63:0] merge(logic [63:0] old_v, logic [63:0] new_v, logic [7:0] strb);
        logic [63:0] mask;
        mask = 64'h0;
        for (int b = 0; b < 8; b++) if (strb[b]) mask[b*8 +: 8] = 8'hFF;
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic logic [63:0] model_read(int i, logic [31:0] addr);
        logic [15:0] ofs;
        ofs = addr[15:0] & 16'hFFF8;
        if (addr[31:16] != BASE[31:16]) return 64'h0;
        case (ofs)
            16'h0000: return MSIP_EN ? {63'h0, msip_v} : 64'h0;
            16'h4000: return cmp_v[i];
            16'hBFF8: return tm(i, edge_n);
            default:  return 64'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            base_v[i] = 64'h0;
            base_e[i] = -1;
            cmp_v[i]  = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        msip_v     = 1'b0;
        pend_valid = 1'b0;
    endtask

    task automatic apply_write(int k);
        logic [15:0] ofs;
        ofs = pend_addr[15:0] & 16'hFFF8;
        for (int i = 0; i < 2; i++) begin
            if (ofs == 16'hBFF8) begin
                base_v[i] = merge(tm(i, k), pend_data, pend_strb);
                base_e[i] = k;
            end else if (ofs == 16'h4000) begin
                cmp_v[i] = merge(cmp_v[i], pend_data, pend_strb);
            end
        end
        if (ofs == 16'h0000 && MSIP_EN && pend_strb[0]) msip_v = pend_data[0];
    endtask

    task automatic chk(string tag, int i, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d: observed=%h expected=%h", tag, i, obs, exp);
        end
    endtask

    // advance one clock, update the model, check the interrupt outputs
    task automatic step();
        logic exp_m [2];
        for (int i = 0; i < 2; i++) exp_m[i] = (tm(i, edge_n) >= cmp_v[i]);
        @(negedge I_clk);
        if (pend_valid) begin
            apply_write(edge_n - 1);
            pend_valid = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            chk("mtip", i, 64'(mtip[i]), 64'(exp_m[i]));
            chk("msip", i, 64'(msip[i]), MSIP_EN ? 64'(msip_v) : 64'h0);
        end
    endtask

    task automatic steps(int n);
        for (int s = 0; s < n; s++) step();
    endtask

    task automatic rd(logic [31:0] addr, string tag);
        logic [63:0] exp_r [2];
        I_araddr  = addr;
        I_arvalid = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arready_idle", i, 64'(arready[i]), 64'h1);
            exp_r[i] = model_read(i, addr);
        end
        step();
        I_arvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rvalid_lat", i, 64'(rvalid[i]), 64'h1);
            chk(tag, i, rdata[i], exp_r[i]);
            rd_obs[i] = rdata[i];
        end
        I_rready = 1'b1;
        step();
        I_rready = 1'b0;
        for (int i = 0; i < 2; i++) chk("rvalid_drop", i, 64'(rvalid[i]), 64'h0);
    endtask

    task automatic wr(logic [31:0] addr, logic [63:0] data, logic [7:0] strb);
        I_awaddr  = addr;
        I_wdata   = data;
        I_wstrb   = strb;
        I_awvalid = 1'b1;
        I_wvalid  = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("awready_idle", i, 64'(awready[i]), 64'h1);
            chk("wready_idle", i, 64'(wready[i]), 64'h1);
        end
        pend_addr  = addr;
        pend_data  = data;
        pend_strb  = strb;
        pend_valid = 1'b1;
        step();
        I_awvalid = 1'b0;
        I_wvalid  = 1'b0;
        for (int i = 0; i < 2; i++) chk("bvalid_lat", i, 64'(bvalid[i]), 64'h1);
        I_bready = 1'b1;
        step();
        I_bready = 1'b0;
        for (int i = 0; i < 2; i++) chk("bvalid_drop", i, 64'(bvalid[i]), 64'h0);
    endtask

    logic [63:0] t0 [2];
    logic [63:0] hold_exp [2];
    logic [63:0] rnd_data;
    logic [12:0] ln;
    logic [31:0] addr_r;

    initial begin
        model_reset();
        repeat (2) @(negedge I_clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_arready", i, 64'(arready[i]), 64'h1);
            chk("rst_awready", i, 64'(awready[i]), 64'h0);
            chk("rst_wready", i, 64'(wready[i]), 64'h0);
            chk("rst_rvalid", i, 64'(rvalid[i]), 64'h0);
            chk("rst_bvalid", i, 64'(bvalid[i]), 64'h0);
            chk("rst_rdata", i, rdata[i], 64'h0);
            chk("rst_mtip", i, 64'(mtip[i]), 64'h0);
            chk("rst_msip", i, 64'(msip[i]), 64'h0);
        end
        I_rst = 1'b1;

        // mtime after release
        steps(10);
        rd(A_TIME, "mtime_after_reset");
        chk("mtime_at_10", 0, rd_obs[0], 64'd10);

        // timer interrupt rise and clear
        wr(A_CMP, 64'd20, 8'hFF);
        steps(90);
        wr(A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        steps(2);

        // partial-strobe write to mtime
        wr(A_TIME, 64'hAAAA_BBBB_0000_0000, 8'hFF);
        wr(A_TIME, 64'h0000_0000_1234_5678, 8'h0F);
        rd(A_TIME, "mtime_strb");
        chk("mtime_strb_hi", 1, 64'(rd_obs[1][63:32]), 64'hAAAA_BBBB);

        // 100-cycle advance between two read captures
        rd(A_TIME, "mtime_t0");
        t0[0] = rd_obs[0];
        t0[1] = rd_obs[1];
        steps(98);
        rd(A_TIME, "mtime_t1");
        chk("delta100", 0, rd_obs[0] - t0[0], 64'd100);
        chk("delta100", 1, rd_obs[1] - t0[1], 64'd25);

        // write lands on a tick edge of the divide-by-4 instance
        for (int g = 0; g < 4 && (edge_n % 4) != 3; g++) step();
        wr(A_TIME, 64'h0000_0000_0000_1000, 8'hFF);
        rd(A_TIME, "mtime_tick_write");
        chk("tick_write_held", 1, rd_obs[1], 64'h1000);

        // 64-bit wrap
        wr(A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
        steps(10);
        rd(A_TIME, "mtime_wrap");

        // msip and unmapped offsets
        wr(A_MSIP, 64'h1, 8'h01);
        rd(A_MSIP, "msip_read");
        rd(BASE + 32'h8, "unmapped_0008");
        wr(BASE + 32'h100, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        rd(BASE + 32'h100, "unmapped_0100");

        // concurrent read and write of mtime with both responses stalled
        I_araddr  = A_TIME;
        I_arvalid = 1'b1;
        I_awaddr  = A_TIME;
        I_wdata   = 64'h0000_0001_0000_0000;
        I_wstrb   = 8'hF0;
        I_awvalid = 1'b1;
        I_wvalid  = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("cc_arready", i, 64'(arready[i]), 64'h1);
            chk("cc_awready", i, 64'(awready[i]), 64'h1);
            hold_exp[i] = model_read(i, A_TIME);
        end
        pend_addr  = A_TIME;
        pend_data  = 64'h0000_0001_0000_0000;
        pend_strb  = 8'hF0;
        pend_valid = 1'b1;
        step();
        for (int h = 0; h < 5; h++) begin
            for (int i = 0; i < 2; i++) begin
                chk("hold_rvalid", i, 64'(rvalid[i]), 64'h1);
                chk("hold_rdata", i, rdata[i], hold_exp[i]);
                chk("hold_arready", i, 64'(arready[i]), 64'h0);
                chk("hold_awready", i, 64'(awready[i]), 64'h0);
                chk("hold_wready", i, 64'(wready[i]), 64'h0);
                chk("hold_bvalid", i, 64'(bvalid[i]), 64'h1);
            end
            step();
        end
        I_arvalid = 1'b0;
        I_awvalid = 1'b0;
        I_wvalid  = 1'b0;
        I_rready  = 1'b1;
        I_bready  = 1'b1;
        step();
        I_rready = 1'b0;
        I_bready = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 2; i++) begin
                chk("cc_rvalid_once", i, 64'(rvalid[i]), 64'h0);
                chk("cc_bvalid_once", i, 64'(bvalid[i]), 64'h0);
            end
            step();
        end
        rd(A_TIME, "cc_write_landed");

        // randomized mix of reads, writes and idles
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0: addr_r = A_MSIP;
                1: addr_r = A_CMP;
                2: addr_r = A_TIME;
                default: begin
                    ln = 13'($urandom_range(1, 8190));
                    if (ln == 13'h0800 || ln == 13'h17FF) ln = 13'h0001;
                    addr_r = BASE + {16'h0, ln, 3'b000};
                end
            endcase
            addr_r = addr_r | 32'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: rd(addr_r, "rand_read");
                1: begin
                    rnd_data = {32'($urandom_range(0, 3)), 32'($urandom)};
                    wr(addr_r, rnd_data, 8'($urandom_range(0, 255)));
                end
                default: steps($urandom_range(1, 3));
            endcase
        end

        // reset in the middle of a read response
        I_araddr  = A_CMP;
        I_arvalid = 1'b1;
        step();
        I_arvalid = 1'b0;
        I_rst = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            chk("midrst_rvalid", i, 64'(rvalid[i]), 64'h0);
            chk("midrst_arready", i, 64'(arready[i]), 64'h1);
            chk("midrst_rdata", i, rdata[i], 64'h0);
            chk("midrst_mtip", i, 64'(mtip[i]), 64'h0);
        end
        steps(2);
        I_rst = 1'b1;
        steps(3);
        rd(A_CMP, "post_rst_cmp");
        rd(A_TIME, "post_rst_mtime");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040750_clint.md
# ysyx_22040750_clint

Core-local interruptor: holds the RISC-V `mtime`, `mtimecmp` and `msip` registers and drives the machine timer and software interrupt lines into the CPU core. It sits downstream of the slave crossbar as an AXI4-Lite slave on the `clint_*` port group and handles all accesses the crossbar decodes to the CLINT window.

## Interface
- `TICK_DIV`, default 1: `mtime` increments once every `TICK_DIV` clocks; legal range 1..65535.
- `BASE_ADDR`, default 32'h0200_0000: base of the 64 KiB CLINT window.
- `I_clk` input 1: the single clock.
- `I_rst` input 1: reset, asynchronous assert, active-low.
- `I_araddr` input 32: read address.
- `I_arvalid` input 1 / `O_arready` output 1: read address handshake.
- `O_rdata` output 64: read data.
- `O_rvalid` output 1 / `I_rready` input 1: read data handshake; crossbar treats `rvalid` as `rlast`.
- `I_awaddr` input 32: write address.
- `I_awvalid` input 1 / `O_awready` output 1: write address handshake.
- `I_wdata` input 64: write data.
- `I_wstrb` input 8: byte strobes.
- `I_wvalid` input 1 / `O_wready` output 1: write data handshake.
- `O_bvalid` output 1 / `I_bready` input 1: write response handshake; no resp field.
- `O_mtip` output 1: timer interrupt pending, registered.
- `O_msip` output 1: software interrupt pending, equal to `msip[0]`.

## Operation
- Register map, offsets from `BASE_ADDR`, 8-byte-aligned lanes on `I_addr[15:3]`:
  - 0x0000 `msip`: bit 0 only, in byte lane 0; all other bits read 0.
  - 0x4000 `mtimecmp`: 64-bit.
  - 0xBFF8 `mtime`: 64-bit.
  - Any other offset reads 64'h0. Writes to it are accepted and dropped.
- Address bits [2:0] are ignored. Strobes select the bytes written.
- Prescaler:
  - Counter counts 0..`TICK_DIV`-1.
  - `mtime` += 1 on the cycle the counter is at `TICK_DIV`-1, then the counter wraps to 0.
  - `mtime` wraps from 2^64-1 to 0.
- `O_mtip` is registered (`mtime` >= `mtimecmp`, unsigned 64-bit) and is updated every cycle.
- Read FSM states:
  - R_IDLE: `O_arready`=1. On `arvalid`, latch the address, go to R_DATA.
  - R_DATA: `O_arready`=0. `O_rvalid`=1 with registered data. On `rready`, go to R_IDLE.
- Write FSM states:
  - W_IDLE: `O_awready` = `O_wready` = `I_awvalid & I_wvalid`, so both channels are accepted together in one cycle. The register is updated on that edge. Go to W_RESP.
  - W_RESP: `O_awready` = `O_wready` = 0. `O_bvalid`=1 until `bready`, then go to W_IDLE.
- Simultaneous events:
  - A software write to `mtime` and a prescaler increment on the same cycle: the write wins, no increment.
  - A read captured on the same edge as a write to the same register returns the pre-write value.
  - The read and write FSMs are independent and may be active concurrently.

## Timing
- Reset values:
  - `mtime`=0, prescaler=0, `msip`=0.
  - `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF.
  - `O_mtip`=0, `O_msip`=0.
  - `O_rvalid`=0, `O_bvalid`=0, `O_rdata`=0.
  - `O_arready`=1, `O_awready`=0, `O_wready`=0.
- Read latency: `ar` handshake at edge N, `O_rvalid`=1 in cycle N+1. Data is held stable while `rready`=0. The next `ar` can be accepted one cycle after the `r` handshake.
- Write latency: `aw`/`w` handshake at edge N, register updated at edge N, `O_bvalid`=1 in cycle N+1.
- `O_mtip` reflects a `mtime`/`mtimecmp` change one cycle after the change.
- Reset asserted mid-transaction: all FSMs and registers return to reset values immediately. An in-flight response is dropped; the crossbar is reset by the same signal.

## Configuration
- `YSYX_22040750_CLINT_MSIP_EN` defined: `msip` register implemented, `O_msip` = `msip[0]`.
- Not defined: offset 0x0000 behaves as unmapped (reads 0, writes dropped) and `O_msip` is tied to 0.

## Structure
- Shared package/header holds:
  - the `CLINT_MSIP_OFS`, `CLINT_MTIMECMP_OFS`, `CLINT_MTIME_OFS` offsets;
  - `BASE_ADDR` default;
  - read/write FSM state encodings.
- One sub-module `ysyx_22040750_clint_timer`:
  - contains the prescaler, `mtime`, `mtimecmp`, the byte-strobed write port and the registered compare;
  - the top holds the AXI4-Lite FSMs and `msip`.

## Test plan
- After reset release, read 0xBFF8 with `TICK_DIV`=1, 10 cycles after release -> `O_rdata` = 9 or 10 (the exact value matches the ar-capture cycle), `rvalid` exactly one cycle after `ar` handshake.
- Write `mtimecmp`=20 with strb 8'hFF -> `bvalid` next cycle. `O_mtip` rises one cycle after `mtime` reaches 20. Writing `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF clears `O_mtip` one cycle later.
- Write `mtime` with strb 8'h0F, data 64'h1234_5678 over `mtime`=64'hAAAA_BBBB_0000_0000 -> readback 64'hAAAA_BBBB_1234_5678 (plus elapsed ticks).
- `TICK_DIV`=4 -> `mtime` advances by exactly 25 over 100 cycles. A write to `mtime` coincident with a tick -> written value held, no +1.
- Write 1 to 0x0000 -> `O_msip`=1 next cycle with the macro defined, 0 without. Read 0x0008 -> 0.
- Hold `rready`=0 for 5 cycles and `bready`=0 for 5 cycles during concurrent read and write -> `O_rdata` stable, `O_arready`/`O_awready` stay 0, and no lost or duplicated response.
